// File: rtl/fir_output_decimator_if.sv
// fir_output_decimator_if: valid/ready result stream from the decimator to its consumer
interface fir_output_decimator_if #(parameter int OUT_W = 8);
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    modport master(output out_data, out_valid, input out_ready);
    modport slave(input out_data, out_valid, output out_ready);
endinterface

// File: rtl/fir_output_decimator.sv
// fir_output_decimator: integrate-and-dump, shift, saturate and FIFO-buffer FIR output samples
// Define FIR_DECIM_ROUND_EN for round-half-up before the shift; default is floor truncation.
module fir_output_decimator #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int DECIM = 4,
    parameter int SHIFT = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [IN_W-1:0]   y_in,
    fir_output_decimator_if.master   bus,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     sat_flag,
    input  logic                     sat_clr,
    output logic                     overflow
);
    localparam int PW = $clog2(DECIM);
    localparam int AW = IN_W + PW;
    localparam int AB = $clog2(DEPTH);
    localparam int CW = AB + 1;
    localparam logic signed [AW:0] MAXV = (AW+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [AW:0] MINV = ~MAXV;
    logic signed [AW-1:0]  acc, sum;
    logic signed [AW:0]    scaled;
    logic [PW-1:0]         phase;
    logic [AB-1:0]         wptr, rptr;
    logic [OUT_W-1:0]      mem [DEPTH];
    logic [OUT_W-1:0]      res;
    logic                  last, push_req, push, pop, full, sat_hi, sat_lo;
    assign sum = acc + {{PW{y_in[IN_W-1]}}, y_in};
`ifdef FIR_DECIM_ROUND_EN
    localparam logic [AW:0] HALF = (AW+1)'(2**(SHIFT-1));
    assign scaled = $signed({sum[AW-1], sum} + HALF) >>> SHIFT;
`else
    assign scaled = $signed({sum[AW-1], sum}) >>> SHIFT;
`endif
    assign sat_hi   = scaled > MAXV;
    assign sat_lo   = scaled < MINV;
    assign res      = sat_hi ? MAXV[OUT_W-1:0] : sat_lo ? MINV[OUT_W-1:0] : scaled[OUT_W-1:0];
    assign last     = phase == PW'(DECIM - 1);
    assign push_req = in_valid && last;
    assign full     = fifo_count == CW'(DEPTH);
    assign pop      = bus.out_valid && bus.out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign push     = push_req && (!full || pop);
    assign bus.out_valid = fifo_count != '0;
    assign bus.out_data  = bus.out_valid ? mem[rptr] : '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc        <= '0;
            phase      <= '0;
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            sat_flag   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (in_valid) begin
                acc   <= last ? '0 : sum;
                phase <= phase + 1'b1;
            end
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            overflow   <= push_req && full && !pop;
            sat_flag   <= (push_req && (sat_hi || sat_lo)) || (sat_flag && !sat_clr);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= res;
    end
endmodule
